l1_cache_bus_unit: RTL and testbench

L1_CACHE_BUS_UNIT -- requirements
Module: l1_cache_bus_unit

---
 rtl/l1_cache_bus_unit.sv | 193 +++++++++++++++++++
 tb/tb_l1_cache_bus_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_cache_bus_unit.sv
// l1_cache_bus_unit
//   Bus side of the L1 cache. Runs one transaction at a time on the external
//   bus: a single write-through, a single read, or a whole-line fill of
//   LINE_WORDS 64-bit beats issued back to back.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   write_through_req      single write request (highest priority)
//   read_line_req          line fill request
//   read_req               single read request (lowest priority)
//   size, pa, wt_data      request attributes, latched when leaving IDLE
//   line_data, addr_count  captured read data and its beat index
//   line_write             cache data-array write strobe (one per line beat)
//   cache_entry_write      line fill complete, update the tag entry
//   trans_rdy, bus_error   one-cycle completion / failure pulses
//   bus_*                  external bus request side; bus_rdata/ack/err back
//
// Build option
//   L1_BU_TIMEOUT_EN       compile in a watchdog that turns TIMEOUT_CYCLES
//                          un-answered bus_req cycles into a bus error.
module l1_cache_bus_unit #(
  parameter int LINE_WORDS     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_through_req,
  input  logic        read_req,
  input  logic        read_line_req,
  input  logic [3:0]  size,
  input  logic [63:0] pa,
  input  logic [63:0] wt_data,
  output logic [63:0] line_data,
  output logic [10:0] addr_count,
  output logic        line_write,
  output logic        cache_entry_write,
  output logic        trans_rdy,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_size,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  input  logic [63:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  // Byte-offset bits of a line; cleared to get the line base address.
  localparam int OFFW = $clog2(LINE_WORDS * 8);

  typedef enum logic [2:0] {IDLE, WRITE, READ, LINE, DONE, FAIL} state_e;

  state_e      state_q, state_d;
  logic [10:0] beat_q, beat_d;
  logic [63:0] pa_q, pa_d;
  logic [3:0]  size_q, size_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] line_data_q, line_data_d;
  logic [10:0] addr_count_q, addr_count_d;
  logic        line_write_q, line_write_d;

  logic        active, ack_now, fail_now, last_beat, timeout;
  logic [63:0] line_base;

  assign active    = (state_q == WRITE) || (state_q == READ) || (state_q == LINE);
  assign ack_now   = active && bus_ack && !bus_err;       // bus_err wins over bus_ack
  assign fail_now  = active && (bus_err || timeout);
  assign last_beat = (beat_q == 11'(LINE_WORDS - 1));
  assign line_base = {pa_q[63:OFFW], {OFFW{1'b0}}};

`ifdef L1_BU_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;

  // Counts un-answered cycles of the current beat; any answer restarts it.
  always_comb begin
    wd_d = '0;
    if (active && !bus_ack && !bus_err) wd_d = wd_q + 1'b1;
  end

  assign timeout = active && !bus_ack && !bus_err && (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      pa_q         <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      line_data_q  <= '0;
      addr_count_q <= '0;
      line_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      pa_q         <= pa_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      line_data_q  <= line_data_d;
      addr_count_q <= addr_count_d;
      line_write_q <= line_write_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    pa_d         = pa_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    line_data_d  = line_data_q;
    addr_count_d = addr_count_q;
    line_write_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        if (write_through_req || read_line_req || read_req) begin
          pa_d    = pa;
          size_d  = size;
          wdata_d = wt_data;
        end
        if (write_through_req)  state_d = WRITE;
        else if (read_line_req) state_d = LINE;
        else if (read_req)      state_d = READ;
      end
      WRITE, READ: begin
        if (fail_now) state_d = FAIL;
        else if (ack_now) begin
          state_d = DONE;
          if (state_q == READ) begin
            line_data_d  = bus_rdata;
            addr_count_d = '0;
          end
        end
      end
      LINE: begin
        if (fail_now) state_d = FAIL;
        else if (ack_now) begin
          line_data_d  = bus_rdata;
          addr_count_d = beat_q;
          line_write_d = 1'b1;
          if (last_beat) state_d = DONE;
          else           beat_d  = beat_q + 11'd1;
        end
      end
      default: state_d = IDLE;  // DONE and FAIL last exactly one cycle
    endcase
  end

  // Bus attributes come straight from latched state, so they stay stable
  // for the whole beat and read as zero outside a transaction.
  always_comb begin
    bus_addr  = '0;
    bus_size  = '0;
    bus_wdata = '0;
    unique case (state_q)
      WRITE: begin
        bus_addr  = pa_q;
        bus_size  = size_q;
        bus_wdata = wdata_q;
      end
      READ: begin
        bus_addr = pa_q;
        bus_size = size_q;
      end
      LINE: begin
        bus_addr = line_base + {50'd0, beat_q, 3'b000};
        bus_size = 4'b1000;
      end
      default: ;
    endcase
  end

  assign bus_req           = active;
  assign bus_we            = (state_q == WRITE);
  assign trans_rdy         = (state_q == DONE);
  assign bus_error         = (state_q == FAIL);
  assign line_write        = line_write_q;
  // Only a line fill reaches DONE with a beat strobe still pending.
  assign cache_entry_write = (state_q == DONE) && line_write_q;
  assign line_data         = line_data_q;
  assign addr_count        = addr_count_q;

endmodule

// File: tb/tb_l1_cache_bus_unit.sv
module tb_l1_cache_bus_unit;
  localparam int LW = 8;
  localparam int K_WR = 0, K_RD = 1, K_LN = 2;

  logic        clk, rst;
  logic        write_through_req, read_req, read_line_req;
  logic [3:0]  size;
  logic [63:0] pa, wt_data;
  logic [63:0] line_data;
  logic [10:0] addr_count;
  logic        line_write, cache_entry_write, trans_rdy, bus_error;
  logic        bus_req, bus_we;
  logic [3:0]  bus_size;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, bus_err;

  int n_pass = 0, n_tot = 0;
  int nwe, dc, nreq, errc;

  l1_cache_bus_unit #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .write_through_req(write_through_req), .read_req(read_req), .read_line_req(read_line_req),
    .size(size), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_write(cache_entry_write), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  typedef struct {
    int          kind;
    logic [63:0] pa;
    logic [3:0]  sz;
    logic [63:0] wd;
    int          waits;
    int          err_beat;
    logic [63:0] seed;
    int          exp_cyc;
    int          exp_lw;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "/bus_req"}, 64'(bus_req), 64'd0);
    chk({nm, "/bus_we"}, 64'(bus_we), 64'd0);
    chk({nm, "/line_write"}, 64'(line_write), 64'd0);
    chk({nm, "/cew"}, 64'(cache_entry_write), 64'd0);
    chk({nm, "/trans_rdy"}, 64'(trans_rdy), 64'd0);
    chk({nm, "/bus_error"}, 64'(bus_error), 64'd0);
    chk({nm, "/line_data"}, line_data, 64'd0);
    chk({nm, "/addr_count"}, 64'(addr_count), 64'd0);
    chk({nm, "/bus_addr"}, bus_addr, 64'd0);
    chk({nm, "/bus_wdata"}, bus_wdata, 64'd0);
    chk({nm, "/bus_size"}, 64'(bus_size), 64'd0);
  endtask

  // Reference: each beat costs waits+1 bus_req cycles; completion or failure
  // shows one cycle after the deciding beat; a failing beat writes nothing.
  task automatic model(input int kind, input int waits, input int err_beat,
                       output int cyc, output int lw, output bit err);
    int beats;
    beats = (kind == K_LN) ? LW : 1;
    if (err_beat >= 0 && err_beat < beats) begin
      err = 1'b1;
      lw  = (kind == K_LN) ? err_beat : 0;
      cyc = err_beat * (waits + 1) + waits + 2;
    end else begin
      err = 1'b0;
      lw  = (kind == K_LN) ? LW : 0;
      cyc = beats * (waits + 1) + 1;
    end
  endtask

  // Issues one transaction from an IDLE cycle, plays the bus, checks every
  // bus beat and strobe, and returns in the IDLE cycle after completion.
  task automatic run_txn(input int kind, input logic [63:0] a, input logic [3:0] sz,
                         input logic [63:0] wd, input int waits, input int err_beat,
                         input logic [63:0] seed, input bit noisy, input bit extra,
                         input int exp_cyc, input int exp_lw, input bit exp_err,
                         input string nm);
    int beat, wcnt, lw, done_cyc;
    logic [63:0] base, ea;
    base = a & ~(64'(LW) * 64'd8 - 64'd1);
    beat = 0; wcnt = 0; lw = 0; done_cyc = 0;
    write_through_req = (kind == K_WR);
    read_line_req     = (kind == K_LN) || (extra && kind == K_WR);
    read_req          = (kind == K_RD) || extra;
    pa = a; size = sz; wt_data = wd;
    for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
      @(posedge clk); #1;
      pa = {$urandom, $urandom}; size = 4'($urandom); wt_data = {$urandom, $urandom};
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = {$urandom, $urandom};
      if (line_write) begin
        chk({nm, "/lw_idx"}, 64'(addr_count), 64'(lw));
        chk({nm, "/lw_data"}, line_data, seed + 64'(lw) * 64'h1111);
        lw++;
      end
      if (trans_rdy || bus_error) begin
        done_cyc = c;
        chk({nm, "/bus_error"}, 64'(bus_error), 64'(exp_err));
        chk({nm, "/trans_rdy"}, 64'(trans_rdy), 64'(!exp_err));
        chk({nm, "/cew"}, 64'(cache_entry_write), 64'(kind == K_LN && !exp_err));
        chk({nm, "/lw_at_done"}, 64'(line_write), 64'(kind == K_LN && !exp_err));
        chk({nm, "/lw_count"}, 64'(lw), 64'(exp_lw));
        chk({nm, "/bus_req_done"}, 64'(bus_req), 64'd0);
        if (kind == K_RD && !exp_err) chk({nm, "/rd_data"}, line_data, seed);
        write_through_req = 1'b0; read_line_req = 1'b0; read_req = 1'b0;
        if (noisy) begin bus_ack = 1'($urandom); bus_err = 1'($urandom); end
      end else if (bus_req) begin
        ea = (kind == K_LN) ? base + 64'(beat) * 64'd8 : a;
        chk({nm, "/addr"}, bus_addr, ea);
        chk({nm, "/we"}, 64'(bus_we), 64'(kind == K_WR));
        chk({nm, "/size"}, 64'(bus_size), 64'((kind == K_LN) ? 4'b1000 : sz));
        if (kind == K_WR) chk({nm, "/wdata"}, bus_wdata, wd);
        if (wcnt < waits) wcnt++;
        else begin
          if (beat == err_beat) begin
            bus_err = 1'b1;
            if (noisy) bus_ack = 1'($urandom);
          end else begin
            bus_ack   = 1'b1;
            bus_rdata = seed + 64'(beat) * 64'h1111;
          end
          beat++; wcnt = 0;
        end
      end else if (noisy) begin
        bus_ack = 1'($urandom); bus_err = 1'($urandom);
      end
    end
    chk({nm, "/done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    write_through_req = 1'b0; read_line_req = 1'b0; read_req = 1'b0;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_err = 1'b0;
    chk({nm, "/post_quiet"}, {60'd0, bus_req, trans_rdy, bus_error, line_write}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    write_through_req = 1'b0; read_req = 1'b0; read_line_req = 1'b0;
    size = '0; pa = '0; wt_data = '0; bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;

    vecs[0] = '{K_RD, 64'h1000, 4'b1000, 64'h0, 0, -1, 64'hDEAD, 2, 0, 1'b0};
    vecs[1] = '{K_LN, 64'h2038, 4'b0001, 64'h0, 0, -1, 64'h100, 9, 8, 1'b0};
    vecs[2] = '{K_WR, 64'h3000, 4'b0100, 64'h55, 2, -1, 64'h0, 4, 0, 1'b0};
    vecs[3] = '{K_LN, 64'h2040, 4'b1000, 64'h0, 0, 3, 64'hA000, 5, 3, 1'b1};
    vecs[4] = '{K_LN, 64'h7FC0, 4'b1000, 64'h0, 1, -1, 64'hB000, 17, 8, 1'b0};
    vecs[5] = '{K_RD, 64'h1234, 4'b0010, 64'h0, 1, 0, 64'hC0, 3, 0, 1'b1};
    vecs[6] = '{K_WR, 64'h88, 4'b0001, 64'hAB, 0, 0, 64'h0, 2, 0, 1'b1};
    vecs[7] = '{K_LN, 64'h40, 4'b1000, 64'h0, 0, 0, 64'hD0, 2, 0, 1'b1};
    vecs[8] = '{K_LN, 64'h100, 4'b1000, 64'h0, 0, 7, 64'hE0, 9, 7, 1'b1};
    vecs[9] = '{K_WR, 64'hFFFF_FFFF_FFFF_FFF8, 4'b1000, 64'h1234_5678_9ABC_DEF0, 3, -1, 64'h0, 5, 0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset/idle_no_req", 64'(bus_req), 64'd0);

    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].kind, vecs[i].pa, vecs[i].sz, vecs[i].wd, vecs[i].waits,
              vecs[i].err_beat, vecs[i].seed, 1'b0, 1'b0, vecs[i].exp_cyc,
              vecs[i].exp_lw, vecs[i].exp_err, $sformatf("v%0d", i));

    // Write and read requested together: write first, read after one IDLE cycle.
    write_through_req = 1'b1; read_req = 1'b1;
    pa = 64'h4000; size = 4'b0100; wt_data = 64'h55;
    nwe = 0; dc = 0;
    for (int c = 1; c <= 12 && dc == 0; c++) begin
      @(posedge clk); #1;
      pa = 64'h9999_0000; wt_data = '0; size = 4'b0001; bus_ack = 1'b0;
      if (trans_rdy) begin
        dc = c; write_through_req = 1'b0; pa = 64'h4100; size = 4'b1000;
      end else if (bus_req) begin
        if (bus_we) nwe++;
        chk("wr_rd/addr", bus_addr, 64'h4000);
        chk("wr_rd/wdata", bus_wdata, 64'h55);
        chk("wr_rd/size", 64'(bus_size), 64'(4'b0100));
        if (c == 3) bus_ack = 1'b1;
      end
    end
    chk("wr_rd/done_cycle", 64'(dc), 64'd4);
    chk("wr_rd/we_cycles", 64'(nwe), 64'd3);
    @(posedge clk); #1;
    chk("wr_rd/idle_gap", 64'(bus_req), 64'd0);
    @(posedge clk); #1;
    chk("wr_rd/rd_req", 64'(bus_req), 64'd1);
    chk("wr_rd/rd_we", 64'(bus_we), 64'd0);
    chk("wr_rd/rd_addr", bus_addr, 64'h4100);
    chk("wr_rd/rd_size", 64'(bus_size), 64'(4'b1000));
    bus_ack = 1'b1; bus_rdata = 64'h77;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("wr_rd/rd_done", 64'(trans_rdy), 64'd1);
    chk("wr_rd/rd_data", line_data, 64'h77);
    chk("wr_rd/rd_no_lw", 64'(line_write), 64'd0);
    read_req = 1'b0;
    @(posedge clk); #1;
    chk("wr_rd/quiet", 64'(bus_req), 64'd0);

    // Reset during beat 5 of a zero-wait line fill.
    read_line_req = 1'b1; pa = 64'h5010; size = 4'b1000;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = 64'(c);
    end
    chk("rst_mid/beat5_addr", bus_addr, 64'h5028);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; read_line_req = 1'b0; bus_ack = 1'b0;
    chk_all_zero("rst_mid");
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("rst_mid/no_pulse", {62'd0, trans_rdy, bus_error}, 64'd0);
    end
    run_txn(K_RD, 64'h8000, 4'b1000, 64'h0, 0, -1, 64'h1357, 1'b0, 1'b0, 2, 0, 1'b0, "rst_mid/rd");

    // Bus that never answers.
    read_req = 1'b1; pa = 64'h6000; size = 4'b1000; bus_ack = 1'b0; bus_err = 1'b0;
    nreq = 0; errc = 0;
`ifdef L1_BU_TIMEOUT_EN
    for (int c = 1; c <= 20 && errc == 0; c++) begin
      @(posedge clk); #1;
      if (bus_error) begin errc = c; read_req = 1'b0; end
      else if (bus_req) nreq++;
    end
    chk("wd/req_cycles", 64'(nreq), 64'd4);
    chk("wd/err_cycle", 64'(errc), 64'd5);
    read_req = 1'b0;
    @(posedge clk); #1;
    chk("wd/quiet", 64'(bus_req), 64'd0);
`else
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus_error) errc++;
      if (bus_req) nreq++;
    end
    chk("nowd/req_cycles", 64'(nreq), 64'd20);
    chk("nowd/no_error", 64'(errc), 64'd0);
    rst = 1'b1; read_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("nowd/rst_clears", 64'(bus_req), 64'd0);
`endif
    @(posedge clk); #1;

    // Random transactions with spurious bus responses while bus_req is low.
    for (int i = 0; i < 40; i++) begin
      int k, w, e, cyc, lwn;
      bit er;
      logic [3:0] sz;
      k  = int'($urandom_range(0, 2));
      w  = int'($urandom_range(0, 3));
      e  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (k == K_LN) ? LW - 1 : 0)) : -1;
      sz = 4'b0001 << $urandom_range(0, 3);
      model(k, w, e, cyc, lwn, er);
      run_txn(k, {$urandom, $urandom}, sz, {$urandom, $urandom}, w, e, {$urandom, $urandom},
              1'b1, 1'($urandom_range(0, 1)), cyc, lwn, er, $sformatf("r%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
